reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default ROB_DEPTH (8): entry count, power of two, at least 2.
REQ-002 SHALL have parameter DEPTH_BITS, default $clog2(DEPTH): tag width.
REQ-003 SHALL have parameter N_WB, default 2: number of parallel writeback (CDB) channels, 1..4.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port alloc_valid, input, 1: dispatch requests a new entry.
REQ-007 SHALL have port alloc_entry, input, rob_entry: contents for the new entry.
REQ-008 SHALL have port alloc_ready, output, 1: the ROB can accept an allocation.
REQ-009 SHALL have port alloc_tag, output, DEPTH_BITS: tag that the next allocation receives (the tail).
REQ-010 SHALL have port wb_valid, input, N_WB: per-channel writeback strobe.
REQ-011 SHALL have port wb_tag, input, N_WB*DEPTH_BITS: per-channel target tag.
REQ-012 SHALL have port wb_value, input, N_WB*DATA_WIDTH: per-channel result.
REQ-013 SHALL have port commit_valid, output, 1: the head entry is valid and ready.
REQ-014 SHALL have port commit_ready, input, 1: retire stage accepts the head.
REQ-015 SHALL have port commit_entry, output, rob_entry: head entry contents.
REQ-016 SHALL have port commit_tag, output, DEPTH_BITS: head tag.
REQ-017 SHALL have ports flush_all (input, 1), flush_younger (input, 1) and flush_tag (input, DEPTH_BITS): recovery controls.
REQ-018 SHALL have ports count (output, DEPTH_BITS+1) and empty (output, 1): occupancy.

Function
REQ-019 SHALL implement a circular buffer with head, tail and count registers; pointers SHALL wrap modulo DEPTH.
REQ-020 SHALL assert alloc_ready = (count != DEPTH), computed from registered count only; a same-cycle commit SHALL NOT free a slot for allocation.
REQ-021 When alloc fires (alloc_valid & alloc_ready), the entry at tail SHALL take alloc_entry, the ready flag SHALL be taken from the alloc_entry input, the entry SHALL be marked valid, and tail SHALL advance by 1.
REQ-022 A writeback SHALL write value and set ready=1 on tag wb_tag[i] one cycle after wb_valid[i], but only if that entry is valid.
REQ-023 Writebacks to invalid entries (including the slot being allocated that cycle) SHALL be ignored.
REQ-024 When two channels target the same tag in the same cycle, the highest channel index SHALL win.
REQ-025 commit_valid, commit_entry and commit_tag SHALL be combinational from the head entry; the commit path SHALL have zero latency.
REQ-026 On commit fire (commit_valid & commit_ready), the head entry SHALL be invalidated and head SHALL advance by 1.
REQ-027 Writeback-to-commit latency SHALL be 1 cycle: an entry is visible as ready in the cycle after its writeback.
REQ-028 flush_all SHALL have top priority: it invalidates all entries and sets head = tail = 0 and count = 0; alloc, writeback and commit in that cycle SHALL be discarded.
REQ-029 flush_younger SHALL invalidate every entry strictly younger than flush_tag and set tail = flush_tag+1.
REQ-030 With flush_younger, a same-cycle commit SHALL still occur, a same-cycle allocation SHALL be dropped, and writebacks to surviving entries SHALL apply.
REQ-031 SHALL ignore flush_younger when flush_tag names an invalid entry.
REQ-032 SHALL update count as: count + alloc_fire - commit_fire in normal operation, and as (flush_tag - head + 1) mod 2^(DEPTH_BITS+1) - commit_fire on flush_younger.
REQ-033 empty SHALL equal (count == 0).

Reset
REQ-034 While rst_n = 0 (asynchronously): head = tail = count = 0, all valid/ready flags = 0, alloc_ready = 1, alloc_tag = 0, commit_valid = 0, empty = 1.
REQ-035 Reset asserted mid-operation SHALL discard all entries without a commit.

Structure
REQ-036 The mips_core_pkg package SHALL hold rob_entry, ROB_DEPTH, ROB_DEPTH_BITS and a new ROB_WB_PORTS constant (default 2); ROB_DEPTH SHALL become 8.
REQ-037 The age comparison (tag younger than flush_tag, relative to head) SHALL live in a sub-module rob_age_compare.

Verification
REQ-038 Reset, then allocate 8 entries tags 0..7 -> alloc_ready=0, count=8; a 9th alloc_valid is not accepted.
REQ-039 Writeback tag 1 then tag 0 -> commit of tag 0 then tag 1 on consecutive cycles, in order, with matching values.
REQ-040 Channels 0 and 1 write tag 3 with 0xAAAA and 0xBBBB in one cycle -> committed value = 0xBBBB.
REQ-041 head=2, tail=7, flush_younger with tag 4 -> tail=5, count=3; tags 5 and 6 are invalid; a later writeback to tag 6 is ignored.
REQ-042 Full ROB with flush_all and commit_ready=1 in the same cycle -> no commit, count=0, empty=1, alloc_tag=0.
REQ-043 10 wrap-around passes with random alloc/commit/writeback -> commit order equals allocation order and count never exceeds 8.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared core types and sizing constants for the MIPS out-of-order core.
// The reorder buffer entry format and its default geometry live here.
package mips_core_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ROB_DEPTH      = 8;
    localparam int ROB_DEPTH_BITS = $clog2(ROB_DEPTH);
    localparam int ROB_WB_PORTS   = 2;

    typedef struct packed {
        logic                  ready;
        logic [4:0]            dest_reg;
        logic [DATA_WIDTH-1:0] value;
        logic [31:0]           pc;
    } rob_entry;

endpackage

// File: rtl/rob_age_compare.sv
// Decides whether a tag is strictly younger than a reference tag, with age
// measured as distance from the current head of the circular buffer.
module rob_age_compare #(
    parameter int DEPTH_BITS = 3
) (
    input  logic [DEPTH_BITS-1:0] head,
    input  logic [DEPTH_BITS-1:0] tag,
    input  logic [DEPTH_BITS-1:0] ref_tag,
    output logic                  younger
);

    logic [DEPTH_BITS-1:0] tag_age_s;
    logic [DEPTH_BITS-1:0] ref_age_s;

    // Modulo distances from head make wrapped pointers compare correctly
    always_comb begin
        tag_age_s = tag - head;
        ref_age_s = ref_tag - head;
        younger   = (tag_age_s > ref_age_s);
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate and commit, out-of-order
// multi-channel writeback, plus full and partial (younger-than-tag) flush.
module reorder_buffer
    import mips_core_pkg::*;
#(
    parameter int DEPTH      = ROB_DEPTH,
    parameter int DEPTH_BITS = $clog2(DEPTH),
    parameter int N_WB       = ROB_WB_PORTS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_valid,
    input  rob_entry                     alloc_entry,
    output logic                         alloc_ready,
    output logic [DEPTH_BITS-1:0]        alloc_tag,
    input  logic [N_WB-1:0]              wb_valid,
    input  logic [N_WB*DEPTH_BITS-1:0]   wb_tag,
    input  logic [N_WB*DATA_WIDTH-1:0]   wb_value,
    output logic                         commit_valid,
    input  logic                         commit_ready,
    output rob_entry                     commit_entry,
    output logic [DEPTH_BITS-1:0]        commit_tag,
    input  logic                         flush_all,
    input  logic                         flush_younger,
    input  logic [DEPTH_BITS-1:0]        flush_tag,
    output logic [DEPTH_BITS:0]          count,
    output logic                         empty
);

    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS+1)'(DEPTH);

    logic [DEPTH_BITS-1:0] head_r;
    logic [DEPTH_BITS-1:0] tail_r;
    logic [DEPTH_BITS:0]   count_r;
    rob_entry              mem_r   [DEPTH];
    logic                  valid_r [DEPTH];

    logic [DEPTH-1:0]      younger_s;
    logic                  flush_young_s;
    logic                  commit_fire_s;
    logic                  alloc_fire_s;
    logic [DEPTH_BITS-1:0] flush_off_s;
    logic [DEPTH_BITS:0]   count_nxt_s;
    logic [DEPTH_BITS-1:0] wb_tag_s [N_WB];
    logic [DATA_WIDTH-1:0] wb_val_s [N_WB];

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        rob_age_compare #(.DEPTH_BITS(DEPTH_BITS)) u_age (
            .head    (head_r),
            .tag     (DEPTH_BITS'(g)),
            .ref_tag (flush_tag),
            .younger (younger_s[g])
        );
    end

    // Output view of the state, fire qualification and next occupancy
    always_comb begin
        alloc_ready   = (count_r != FULL_COUNT);
        alloc_tag     = tail_r;
        commit_tag    = head_r;
        commit_entry  = mem_r[head_r];
        commit_valid  = valid_r[head_r] & mem_r[head_r].ready;
        count         = count_r;
        empty         = (count_r == (DEPTH_BITS+1)'(0));
        flush_young_s = flush_younger & valid_r[flush_tag] & ~flush_all;
        commit_fire_s = commit_valid & commit_ready & ~flush_all;
        alloc_fire_s  = alloc_valid & alloc_ready & ~flush_all & ~flush_young_s;
        flush_off_s   = flush_tag - head_r;
        // A younger flush keeps head..flush_tag inclusive, so occupancy is distance+1
        if (flush_young_s) begin
            count_nxt_s = {1'b0, flush_off_s} + (DEPTH_BITS+1)'(1)
                        - {{DEPTH_BITS{1'b0}}, commit_fire_s};
        end else begin
            count_nxt_s = count_r + {{DEPTH_BITS{1'b0}}, alloc_fire_s}
                        - {{DEPTH_BITS{1'b0}}, commit_fire_s};
        end
        for (int i = 0; i < N_WB; i++) begin
            wb_tag_s[i] = wb_tag[i*DEPTH_BITS +: DEPTH_BITS];
            wb_val_s[i] = wb_value[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Buffer state: later statements override earlier ones for the same slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i]   <= '0;
                valid_r[i] <= 1'b0;
            end
        end else if (flush_all) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else begin
            // Ascending channel order lets the highest index win a tag conflict
            for (int i = 0; i < N_WB; i++) begin
                if (wb_valid[i] && valid_r[wb_tag_s[i]]) begin
                    mem_r[wb_tag_s[i]].value <= wb_val_s[i];
                    mem_r[wb_tag_s[i]].ready <= 1'b1;
                end
            end
            if (commit_fire_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + DEPTH_BITS'(1);
            end
            if (flush_young_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (younger_s[i]) begin
                        valid_r[i] <= 1'b0;
                    end
                end
                tail_r <= flush_tag + DEPTH_BITS'(1);
            end
            if (alloc_fire_s) begin
                mem_r[tail_r]   <= alloc_entry;
                valid_r[tail_r] <= 1'b1;
                tail_r          <= tail_r + DEPTH_BITS'(1);
            end
            count_r <= count_nxt_s;
        end
    end

endmodule
